mem_port_arbiter: RTL

- Two-requester arbiter and sequencer for the single genrom read port that the cpu core drives (mem_addr / mem_extra / mem_data / mem_error).
- Shares the port between instruction fetch (bytecode, br_table target tables) and data reads (linear memory / stack spill).
- Programs the genrom lower/upper bound window per grant, so each requester is range-checked against its own region.
- Sits between the cpu core and the ROM instance in the top-level and in the cpu testbenches.

---
 rtl/mem_port_arbiter_if.sv | 59 +++++
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch/data requester handshakes, bound windows and the shared ROM read port.
// The slave modport is the arbiter's view; master is the core-plus-ROM side.
interface mem_port_arbiter_if #(
    parameter int MEM_ADDR  = 6,
    parameter int MEM_EXTRA = 4
);
    localparam int AW = MEM_ADDR + 1;
    localparam int DW = (2 ** MEM_EXTRA) * 8;

    logic                 fetch_req;
    logic [AW-1:0]        fetch_addr;
    logic [MEM_EXTRA-1:0] fetch_extra;
    logic                 fetch_ack;
    logic [DW-1:0]        fetch_data;
    logic                 fetch_error;

    logic                 data_req;
    logic [AW-1:0]        data_addr;
    logic [MEM_EXTRA-1:0] data_extra;
    logic                 data_ack;
    logic [DW-1:0]        data_data;
    logic                 data_error;

    logic [AW-1:0]        code_lower;
    logic [AW-1:0]        code_upper;
    logic [AW-1:0]        heap_lower;
    logic [AW-1:0]        heap_upper;

    logic [AW-1:0]        mem_addr;
    logic [MEM_EXTRA-1:0] mem_extra;
    logic [AW-1:0]        mem_lower_bound;
    logic [AW-1:0]        mem_upper_bound;
    logic [DW-1:0]        mem_data;
    logic                 mem_error;

    logic                 busy;

    modport slave (
        input  fetch_req, fetch_addr, fetch_extra,
        output fetch_ack, fetch_data, fetch_error,
        input  data_req, data_addr, data_extra,
        output data_ack, data_data, data_error,
        input  code_lower, code_upper, heap_lower, heap_upper,
        output mem_addr, mem_extra, mem_lower_bound, mem_upper_bound,
        input  mem_data, mem_error,
        output busy
    );

    modport master (
        output fetch_req, fetch_addr, fetch_extra,
        input  fetch_ack, fetch_data, fetch_error,
        output data_req, data_addr, data_extra,
        input  data_ack, data_data, data_error,
        output code_lower, code_upper, heap_lower, heap_upper,
        input  mem_addr, mem_extra, mem_lower_bound, mem_upper_bound,
        output mem_data, mem_error,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin fetch/data arbiter for the single ROM read port; ack arrives 2 cycles after grant.
// Requesters hold req until their one-cycle ack; the loser simply waits, peak 1 read per 2 cycles.
module mem_port_arbiter #(
    parameter int MEM_ADDR  = 6,
    parameter int MEM_EXTRA = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int AW = MEM_ADDR + 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic {OWN_FETCH = 1'b0, OWN_DATA = 1'b1} owner_t;

    state_t               state_q, state_d;
    owner_t               owner_q, owner_d;
    owner_t               winner;
    logic [AW-1:0]        addr_q, addr_d;
    logic [AW-1:0]        lo_q, lo_d;
    logic [AW-1:0]        hi_q, hi_d;
    logic [MEM_EXTRA-1:0] extra_q, extra_d;
    logic                 fetch_cand;
    logic                 data_cand;
    logic                 fetch_ack_w;
    logic                 data_ack_w;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= OWN_DATA;
            addr_q  <= '0;
            extra_q <= '0;
            lo_q    <= '0;
            hi_q    <= '1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            extra_q <= extra_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        extra_d    = extra_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        fetch_cand = 1'b0;
        data_cand  = 1'b0;
        winner     = OWN_FETCH;

        case (state_q)
            IDLE: begin
                fetch_cand = bus.fetch_req;
                data_cand  = bus.data_req;
            end
            WAIT: state_d = RESP;
            RESP: begin
                // The owner being acked this cycle is masked so the other side gets the next slot.
                fetch_cand = bus.fetch_req && (owner_q != OWN_FETCH);
                data_cand  = bus.data_req  && (owner_q != OWN_DATA);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (fetch_cand && data_cand) begin
            if (owner_q == OWN_DATA) winner = OWN_FETCH;
            else                     winner = OWN_DATA;
        end else if (data_cand) begin
            winner = OWN_DATA;
        end

        if (fetch_cand || data_cand) begin
            state_d = WAIT;
            owner_d = winner;
            if (winner == OWN_FETCH) begin
                addr_d  = bus.fetch_addr;
                extra_d = bus.fetch_extra;
                lo_d    = bus.code_lower;
                hi_d    = bus.code_upper;
            end else begin
                addr_d  = bus.data_addr;
                extra_d = bus.data_extra;
                lo_d    = bus.heap_lower;
                hi_d    = bus.heap_upper;
            end
        end
    end

    assign fetch_ack_w = (state_q == RESP) && (owner_q == OWN_FETCH);
    assign data_ack_w  = (state_q == RESP) && (owner_q == OWN_DATA);

    assign bus.fetch_ack   = fetch_ack_w;
    assign bus.fetch_data  = fetch_ack_w ? bus.mem_data : '0;
    assign bus.fetch_error = fetch_ack_w && bus.mem_error;
    assign bus.data_ack    = data_ack_w;
    assign bus.data_data   = data_ack_w ? bus.mem_data : '0;
    assign bus.data_error  = data_ack_w && bus.mem_error;

    assign bus.mem_addr        = addr_q;
    assign bus.mem_extra       = extra_q;
    assign bus.mem_lower_bound = lo_q;
    assign bus.mem_upper_bound = hi_q;
    assign bus.busy            = (state_q != IDLE);
endmodule
